// File: rtl/mult_div_if.sv
// Request/result bundle for mult_div_unit: operands and op in, status and hi/lo result out.
interface mult_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle on
// operand magnitudes, followed by a single sign-correction cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input logic        clk,
  input logic        reset,
  mult_div_if.slave  bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;  // mult: upper partial product; div: partial remainder
  logic [WIDTH-1:0] q_q, q_d;      // mult: multiplier/lower product; div: dividend/quotient
  logic [WIDTH-1:0] m_q, m_d;      // multiplicand or divisor magnitude
  logic             is_div_q, is_div_d;
  logic             neg_hi_q, neg_hi_d;
  logic             neg_lo_q, neg_lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             signed_op;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    q_d        = q_q;
    m_d        = m_q;
    is_div_d   = is_div_q;
    neg_hi_d   = neg_hi_q;
    neg_lo_d   = neg_lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    signed_op  = SIGNED_EN && !bus.op[0];
    sign_a     = signed_op && bus.a[WIDTH-1];
    sign_b     = signed_op && bus.b[WIDTH-1];
    sum        = {1'b0, acc_q} + {1'b0, (q_q[0] ? m_q : '0)};
    sh         = {acc_q, q_q[WIDTH-1]};
    diff       = sh - {1'b0, m_q};
    prod       = {acc_q, q_q};

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d    = '0;
          q_d      = sign_a ? -bus.a : bus.a;
          m_d      = sign_b ? -bus.b : bus.b;
          is_div_d = bus.op[1];
          neg_lo_d = sign_a ^ sign_b;
          // Remainder follows the dividend; a product is negated as a whole.
          neg_hi_d = bus.op[1] ? sign_a : (sign_a ^ sign_b);
          busy_d   = 1'b1;
          if (bus.op[1] && (bus.b == '0)) begin
            state_d    = StDone;
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            state_d = StRun;
            cnt_d   = CntW'(WIDTH);
          end
        end
      end
      StRun: begin
        if (is_div_q) begin
          if (!diff[WIDTH]) begin
            acc_d = diff[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = sh[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = sum[WIDTH:1];
          q_d   = {sum[0], q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = neg_hi_q ? -acc_q : acc_q;
          lo_d = neg_lo_q ? -q_q : q_q;
        end else begin
          {hi_d, lo_d} = neg_lo_q ? -prod : prod;
        end
        state_d = StDone;
        done_d  = 1'b1;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      m_q        <= '0;
      is_div_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      m_q        <= m_d;
      is_div_q   <= is_div_d;
      neg_hi_q   <= neg_hi_d;
      neg_lo_q   <= neg_lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic reference model.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  mult_div_if #(.WIDTH(32)) bus ();
  mult_div_if #(.WIDTH(8))  bus8 ();

  mult_div_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mult_div_unit #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {div_zero, hi, lo}; divide-by-zero keeps the previous result.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] ph,
                                        input logic [31:0] pl);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] ua = {32'h0, a};
    logic [63:0] ub = {32'h0, b};
    logic [63:0] p;
    logic [63:0] r;
    case (op)
      2'b00: begin p = 64'(sa * sb); return {1'b0, p}; end
      2'b01: begin p = ua * ub; return {1'b0, p}; end
      2'b10: begin
        if (b == 32'h0) return {1'b1, ph, pl};
        p = 64'(sa / sb);
        r = 64'(sa % sb);
        return {1'b0, r[31:0], p[31:0]};
      end
      default: begin
        if (b == 32'h0) return {1'b1, ph, pl};
        return {1'b0, 32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit repulse);
    logic [64:0] res;
    int n;
    int lat;
    res = model(op, a, b, exp_hi, exp_lo);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 2'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
    check("busy_after_start", 64'(bus.busy), 64'd1);
    n = 0;
    lat = -1;
    while (n < 100) begin
      if (bus.done) begin
        lat = n + 1;
        break;
      end
      if (n == 32) begin
        check("hi_hold", 64'(bus.hi), 64'(exp_hi));
        check("lo_hold", 64'(bus.lo), 64'(exp_lo));
      end
      if (repulse && (n == 5 || n == 20)) begin
        bus.start = 1'b1;
        bus.op = 2'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check("latency", 64'(lat), (res[64] ? 64'd1 : 64'd34));
    check("div_zero", 64'(bus.div_zero), 64'(res[64]));
    check("hi", 64'(bus.hi), 64'(res[63:32]));
    check("lo", 64'(bus.lo), 64'(res[31:0]));
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    @(negedge clk);
    check("done_pulse", 64'(bus.done), 64'd0);
    check("busy_clear", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int n;
    int lat;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus8.start = 1'b0;
    bus8.op = '0;
    bus8.a = '0;
    bus8.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);

    // Reset overrides a simultaneous start.
    bus.start = 1'b1;
    bus.op = 2'b00;
    @(negedge clk);
    check("rst_over_start", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;
    reset = 1'b0;

    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    do_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    do_op(2'b11, 32'h0000_0064, 32'h0000_0000, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b00, 32'h1234_5678, 32'h8765_4321, 1'b1);

    // Reset in the middle of a divide: no done pulse, results cleared.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b10;
    bus.a = 32'd1000;
    bus.b = 32'd7;
    @(posedge clk);
    repeat (10) @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    check("abort_no_done", 64'(n), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    do_op(2'b10, 32'd1000, 32'd7, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'(int'($urandom_range(0, 20)) - 10);
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op(2'($urandom), ra, rb, bit'($urandom_range(0, 1)));
    end

    // Unsigned-only 8-bit instance: a signed mult runs as multu.
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.op = 2'b00;
    bus8.a = 8'hFF;
    bus8.b = 8'h02;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    lat = -1;
    for (int k = 0; k < 50; k++) begin
      if (bus8.done) begin
        lat = k + 1;
        break;
      end
      @(negedge clk);
    end
    check("w8_latency", 64'(lat), 64'd10);
    check("w8_hi", 64'(bus8.hi), 64'h01);
    check("w8_lo", 64'(bus8.lo), 64'hFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
